// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: widths, requester IDs,
// FSM state encoding and the round-robin pick.
package mem_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_0 = 3'd1,
    ST_BUSY_1 = 3'd2,
    ST_DONE_0 = 3'd3,
    ST_DONE_1 = 3'd4
  } state_e;

  // On a tie the requester that did not win last time gets the port.
  function automatic logic rr_pick(input logic req_0, input logic req_1, input logic last);
    if (req_0 && req_1) begin
      return ~last;
    end
    return req_1 ? REQ_DATA : REQ_FETCH;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// slave: the arbiter; master: requesters plus memory.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              req_0;
  logic [DATA_W-1:0] addr_0;
  logic              req_1;
  logic [DATA_W-1:0] addr_1;
  logic              we_1;
  logic [DATA_W-1:0] wdata_1;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              grant_0;
  logic              grant_1;
  logic              done_0;
  logic              done_1;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              addr_sel;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  req_0, addr_0, req_1, addr_1, we_1, wdata_1, mem_ready, mem_rdata,
    output grant_0, grant_1, done_0, done_1, err, rdata, addr_sel,
           mem_addr, mem_en, mem_we, mem_wdata
  );

  modport master (
    output req_0, addr_0, req_1, addr_1, we_1, wdata_1, mem_ready, mem_rdata,
    input  grant_0, grant_1, done_0, done_1, err, rdata, addr_sel,
           mem_addr, mem_en, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// 32-bit 2:1 address multiplexer feeding the shared memory port.
module mux_32_bit
  import mem_port_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic              select,
  output logic [DATA_W-1:0] out
);

  assign out = select ? in_1 : in_0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the single shared memory port:
// fetch (requester 0) and data (requester 1), bounded wait on mem_ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus
);

  state_e            state_q;
  logic              last_q;
  logic              addr_sel_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              grant_0_q;
  logic              grant_1_q;
  logic              done_0_q;
  logic              done_1_q;
  logic              err_q;
  logic              mem_en_q;
  logic              mem_we_q;

  logic              winner;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;
  logic              in_busy_1;

  assign winner      = rr_pick(bus.req_0, bus.req_1, last_q);
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
  assign in_busy_1   = (state_q == ST_BUSY_1);

  // Outputs are registered alongside the state so every port-level signal
  // comes straight off a flop; err_q doubles as the timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      addr_sel_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      grant_0_q  <= 1'b0;
      grant_1_q  <= 1'b0;
      done_0_q   <= 1'b0;
      done_1_q   <= 1'b0;
      err_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_0 || bus.req_1) begin
            state_q    <= winner ? ST_BUSY_1 : ST_BUSY_0;
            last_q     <= winner;
            addr_sel_q <= winner;
            cnt_q      <= '0;
            grant_0_q  <= ~winner;
            grant_1_q  <= winner;
            mem_en_q   <= 1'b1;
            mem_we_q   <= winner & bus.we_1;
          end
        end

        ST_BUSY_0, ST_BUSY_1: begin
          if (!bus.mem_ready) begin
            cnt_q <= cnt_inc;
          end
          if (bus.mem_ready || timeout_hit) begin
            state_q  <= in_busy_1 ? ST_DONE_1 : ST_DONE_0;
            done_0_q <= ~in_busy_1;
            done_1_q <= in_busy_1;
            err_q    <= ~bus.mem_ready;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
          end
          // Writes leave the last read value in place.
          if (bus.mem_ready && !mem_we_q) begin
            rdata_q <= bus.mem_rdata;
          end
        end

        ST_DONE_0, ST_DONE_1: begin
          state_q   <= ST_IDLE;
          grant_0_q <= 1'b0;
          grant_1_q <= 1'b0;
          done_0_q  <= 1'b0;
          done_1_q  <= 1'b0;
          err_q     <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mux_32_bit u_addr_mux (
    .in_0   (bus.addr_0),
    .in_1   (bus.addr_1),
    .select (addr_sel_q),
    .out    (bus.mem_addr)
  );

  assign bus.grant_0   = grant_0_q;
  assign bus.grant_1   = grant_1_q;
  assign bus.done_0    = done_0_q;
  assign bus.done_1    = done_1_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.addr_sel  = addr_sel_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = bus.wdata_1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of round-robin, latency and read data.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int T = 15;

  logic clk = 1'b0;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory responder control: mem_ready rises in BUSY cycle number mem_delay.
  int          mem_delay = 0;
  logic [31:0] rsp_data  = 32'h0;
  int          bcnt      = 0;

  // Reference model state.
  int          model_last = 1;
  bit          pend0 = 1'b0;
  bit          pend1 = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] a0 = 32'h0;
  logic [31:0] a1 = 32'h0;
  logic [31:0] wd1 = 32'h0;
  bit          we1 = 1'b0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_en) begin
      bus.mem_ready <= (bcnt == mem_delay);
      bus.mem_rdata <= (bcnt == mem_delay) ? rsp_data : ~rsp_data;
      bcnt          <= bcnt + 1;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= ~rsp_data;
      bcnt          <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic raise0(input logic [31:0] a);
    bus.addr_0 = a;
    a0         = a;
    bus.req_0  = 1'b1;
    pend0      = 1'b1;
  endtask

  task automatic load1(input logic [31:0] a, input bit we, input logic [31:0] d);
    bus.addr_1  = a;
    bus.we_1    = we;
    bus.wdata_1 = d;
    a1  = a;
    we1 = we;
    wd1 = d;
  endtask

  task automatic raise1(input logic [31:0] a, input bit we, input logic [31:0] d);
    load1(a, we, d);
    bus.req_1 = 1'b1;
    pend1     = 1'b1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    pend0     = 1'b0;
    pend1     = 1'b0;
    @(negedge clk);
    check("reset_ctrl", 32'({bus.grant_1, bus.grant_0, bus.done_1, bus.done_0,
                             bus.err, bus.mem_en, bus.mem_we, bus.addr_sel}), 32'h0);
    check("reset_rdata", bus.rdata, 32'h0);
    rst_n      = 1'b1;
    model_last = 1;
    exp_rdata  = 32'h0;
  endtask

  // Called at a negedge with the DUT in IDLE and requests already presented.
  task automatic run_access(input bit late1, output int owner);
    int          w;
    int          lat;
    bit          exp_err;
    bit          is_rd;
    bit          seen;
    logic [31:0] a_w;
    w       = (pend0 && pend1) ? ((model_last == 0) ? 1 : 0) : (pend1 ? 1 : 0);
    lat     = (mem_delay + 1 < T) ? mem_delay + 1 : T;
    exp_err = (mem_delay >= T);
    is_rd   = (w == 0) || !we1;
    a_w     = (w == 0) ? a0 : a1;
    owner   = -1;
    seen    = 1'b0;
    for (int c = 1; c <= T + 4 && !seen; c++) begin
      @(negedge clk);
      if (late1 && c == 1) begin
        bus.req_1 = 1'b1;
        pend1     = 1'b1;
      end
      if (c == 1) owner = bus.grant_1 ? 1 : (bus.grant_0 ? 0 : -1);
      if (bus.done_0 || bus.done_1) begin
        seen = 1'b1;
        if (is_rd && !exp_err) exp_rdata = rsp_data;
        check("latency", 32'(c), 32'(lat + 1));
        check("done_ctrl", 32'({bus.grant_1, bus.grant_0, bus.done_1, bus.done_0, bus.err, bus.mem_en}),
              32'({w == 1, w == 0, w == 1, w == 0, exp_err, 1'b0}));
        check("rdata", bus.rdata, exp_rdata);
      end else begin
        check("busy_ctrl", 32'({bus.grant_1, bus.grant_0, bus.addr_sel, bus.mem_en, bus.mem_we, bus.err}),
              32'({w == 1, w == 0, w == 1, 1'b1, (w == 1) && we1, 1'b0}));
        check("mem_addr", bus.mem_addr, a_w);
        if (w == 1) check("mem_wdata", bus.mem_wdata, wd1);
      end
    end
    n_tests++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL done_wait: no done within %0d cycles, expected after %0d", T + 4, lat + 1);
    end
    if (w == 0) begin
      bus.req_0 = 1'b0;
      pend0     = 1'b0;
    end else begin
      bus.req_1 = 1'b0;
      pend1     = 1'b0;
    end
    model_last = w;
    @(negedge clk);
    check("idle_ctrl", 32'({bus.grant_1, bus.grant_0, bus.done_1, bus.done_0,
                            bus.err, bus.mem_en, bus.mem_we, bus.addr_sel}), 32'(w == 1));
  endtask

  initial begin
    int owner;
    rst_n       = 1'b0;
    bus.req_0   = 1'b0;
    bus.addr_0  = 32'h0;
    bus.req_1   = 1'b0;
    bus.addr_1  = 32'h0;
    bus.we_1    = 1'b0;
    bus.wdata_1 = 32'h0;

    // Single fetch, memory answers in the first BUSY cycle.
    do_reset();
    raise0(32'h0000_0040);
    mem_delay = 0;
    rsp_data  = 32'hDEAD_BEEF;
    run_access(1'b0, owner);
    check("fetch_owner", 32'(owner), 32'(0));
    check("fetch_rdata", bus.rdata, 32'hDEAD_BEEF);

    // Simultaneous requests after reset alternate 0,1,0,1.
    do_reset();
    raise0(32'h0000_0100);
    raise1(32'h0000_0200, 1'b0, 32'h0);
    mem_delay = 1;
    for (int i = 0; i < 4; i++) begin
      rsp_data = 32'hA000_0000 + 32'(i);
      run_access(1'b0, owner);
      check("rr_seq", 32'(owner), 32'(i % 2));
      if (!pend0) raise0(32'h0000_0100 + 32'(i * 4));
      if (!pend1) raise1(32'h0000_0200 + 32'(i * 4), 1'b0, 32'h0);
    end
    run_access(1'b0, owner);
    check("rr_seq_tail", 32'(owner), 32'(0));
    run_access(1'b0, owner);
    check("rr_seq_tail2", 32'(owner), 32'(1));

    // Data write keeps rdata.
    raise1(32'h0000_1000, 1'b1, 32'h1234_5678);
    mem_delay = 2;
    rsp_data  = 32'h5555_AAAA;
    run_access(1'b0, owner);
    check("write_owner", 32'(owner), 32'(1));

    // Read that never completes times out, then a normal access follows.
    raise1(32'h0000_2000, 1'b0, 32'h0);
    mem_delay = 1000;
    rsp_data  = 32'h0BAD_0BAD;
    run_access(1'b0, owner);
    raise0(32'h0000_0080);
    mem_delay = 0;
    rsp_data  = 32'hCAFE_F00D;
    run_access(1'b0, owner);
    check("after_timeout_rdata", bus.rdata, 32'hCAFE_F00D);

    // Reset in the middle of BUSY_0, then the held request is serviced again.
    raise0(32'h0000_0300);
    mem_delay = 50;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", 32'({bus.grant_0, bus.mem_en}), 32'h3);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", 32'({bus.grant_0, bus.grant_1, bus.mem_en, bus.mem_we,
                              bus.addr_sel, bus.done_0, bus.done_1, bus.err}), 32'h0);
    check("async_reset_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    check("no_done_in_reset", 32'({bus.done_0, bus.done_1}), 32'h0);
    rst_n      = 1'b1;
    model_last = 1;
    exp_rdata  = 32'h0;
    mem_delay  = 0;
    rsp_data   = 32'h7777_0001;
    run_access(1'b0, owner);
    check("reissue_owner", 32'(owner), 32'(0));

    // Data request arriving during BUSY_0 waits for the fetch to finish.
    raise0(32'h0000_0500);
    load1(32'h0000_0600, 1'b0, 32'h0);
    mem_delay = 3;
    rsp_data  = 32'h1111_2222;
    run_access(1'b1, owner);
    check("late_first_owner", 32'(owner), 32'(0));
    mem_delay = 0;
    rsp_data  = 32'h3333_4444;
    run_access(1'b0, owner);
    check("late_second_owner", 32'(owner), 32'(1));

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) raise0($urandom);
      if (!pend1 && (!pend0 || $urandom_range(0, 1) == 1))
        raise1($urandom, 1'($urandom_range(0, 1)), $urandom);
      mem_delay = ($urandom_range(0, 4) == 0) ? int'($urandom_range(T - 2, T + 2))
                                              : int'($urandom_range(0, 3));
      rsp_data  = $urandom;
      run_access(1'b0, owner);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared 32-bit memory port of the multi-cycle datapath. Requester 0 is instruction fetch (read-only); requester 1 is data access (read/write). The block grants the port round-robin and drives the 32-bit 2:1 address mux select. It runs a handshaked access against the memory with a bounded wait, then returns read data and a one-cycle completion pulse to the winner.

## Interface
- `TIMEOUT`, 15: maximum BUSY cycles waiting for `mem_ready` before the access is aborted; range 1..255.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_0`  in  1  fetch request; held high with `addr_0` stable until `done_0`.
- `addr_0`  in  32  fetch address.
- `req_1`  in  1  data request; held high with `addr_1`/`we_1`/`wdata_1` stable until `done_1`.
- `addr_1`  in  32  data address.
- `we_1`  in  1  1 = write, 0 = read.
- `wdata_1`  in  32  write data.
- `mem_ready`  in  1  memory completion, sampled only in BUSY states.
- `mem_rdata`  in  32  memory read data, valid when `mem_ready`=1.
- `grant_0`, `grant_1`  out  1 each  owner of the port; one-hot or both 0.
- `done_0`, `done_1`  out  1 each  one-cycle completion pulse to the owner.
- `err`  out  1  one-cycle pulse alongside `done_x` when the access timed out.
- `rdata`  out  32  captured read data; holds until the next capture.
- `addr_sel`  out  1  mux select: 0 = `addr_0`, 1 = `addr_1`.
- `mem_addr`  out  32  mux output to memory.
- `mem_en`  out  1  access strobe.
- `mem_we`  out  1  write strobe.
- `mem_wdata`  out  32  equals `wdata_1`.

## Operation
- States: IDLE, BUSY_0, BUSY_1, DONE_0, DONE_1. Moore outputs decoded from the state register. `addr_sel` and `last` are registered.
- IDLE: if only `req_x`, go to BUSY_x. If both, grant the requester not equal to `last`. On entering BUSY_x, set `last`=x, set `addr_sel`=x, clear the counter.
- BUSY_x: `grant_x`=1, `mem_en`=1, `mem_we`=`we_1` in BUSY_1 and 0 in BUSY_0.
  - `mem_ready`=1: capture `mem_rdata` into `rdata` (reads only; writes leave `rdata` unchanged), go to DONE_x.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to DONE_x with the error flag set. `rdata` is unchanged.
- DONE_x: `done_x`=1, `err`=flag, `grant_x`=1, `mem_en`=0. Always return to IDLE and clear the flag.
- A request arriving during the other requester's BUSY/DONE waits. No preemption.
- `req_x` still high in the IDLE after DONE_x counts as a new request. Round-robin still gives the other requester priority if it is pending.
- `addr_sel` keeps its last value in IDLE.
- Reset values: state IDLE; `grant_*`, `done_*`, `err`, `mem_en`, `mem_we` = 0; `addr_sel`=0; `rdata`=0; `last`=1 (requester 0 wins the first tie); counter 0; error flag 0.

## Timing
- Request sampled at edge k in IDLE; BUSY from cycle k+1.
- `mem_ready` high in cycle k+1 gives DONE in k+2. Minimum request-to-done latency is 2 cycles; the port is free again in k+3.
- A timeout ends BUSY after TIMEOUT cycles, so `done_x`/`err` appear TIMEOUT+1 cycles after BUSY entry.
- `mem_addr` is combinational from `addr_sel` and the addresses. It is stable for all of BUSY.
- Reset asserted mid-access: outputs go to their reset values immediately (asynchronous). No `done` is issued; the requester must reissue.
- Back-to-back with both requesting continuously: grants alternate 0,1,0,1. Each access takes ≥3 cycles including IDLE.

## Structure
- Shared header `constant_values.h`: state encodings (3-bit), requester IDs, data width 32.
- One sub-module: the existing `mux_32_bit`, instantiated with `in_0`=`addr_0`, `in_1`=`addr_1`, `select`=`addr_sel`, `out`=`mem_addr`.
- Counter width is 8 bits.

## Test plan
- Reset, then `req_0`=1, `addr_0`=32'h0000_0040, `mem_ready` high in the first BUSY cycle with `mem_rdata`=32'hDEAD_BEEF -> `addr_sel`=0, `mem_addr`=32'h40, `done_0` pulses 2 cycles after the request, `rdata`=32'hDEAD_BEEF.
- `req_0` and `req_1` rise on the same edge after reset -> requester 0 is granted first. Holding both produces a grant sequence of 0,1,0,1 with `addr_sel` tracking it.
- `req_1`=1, `we_1`=1, `addr_1`=32'h0000_1000, `wdata_1`=32'h1234_5678 -> `mem_we`=1 and `mem_addr`=32'h1000 throughout BUSY_1. On `done_1`, `rdata` holds its prior value.
- `req_1` read with `mem_ready` held low -> `done_1` and `err` pulse together exactly TIMEOUT+1 cycles after BUSY entry. The next access proceeds normally.
- `rst_n` pulled low in the middle of BUSY_0 -> `mem_en`, `grant_0` and `addr_sel` drop immediately with no `done_0`. After release, the same request is serviced from IDLE.
- `req_1` raised during BUSY_0 -> no grant change until DONE_0. `grant_1` is asserted 2 cycles after `done_0`.
